spi_reg_master: RTL and testbench
=================================

SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, spi_clk half-period in sclk cycles; legal range 1..255.
REQ-002 SHALL have port sclk  input  1  system clock; all sequential logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  transaction request; sampled only while idle.
REQ-005 SHALL have port rw  input  1  1 = register read, 0 = register write.
REQ-006 SHALL have port addr  input  7  register address.
REQ-007 SHALL have port wdata  input  8  write data.
REQ-008 SHALL have port busy  output  1  transaction in progress.
REQ-009 SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port rdata  output  8  last read result.
REQ-011 SHALL have port spi_clk  output  1  SPI serial clock, CPOL=0.
REQ-012 SHALL have port spi_mosi  output  1  serial data to peripheral.
REQ-013 SHALL have port spi_miso  input  1  serial data from peripheral.
REQ-014 SHALL have port spi_cs_n  output  1  chip select, active-low.

Function
REQ-015 SHALL use SPI mode CPHA=1: spi_mosi updated at the sclk edge where spi_clk rises; spi_miso captured at the sclk edge where spi_clk falls; MSB first.
REQ-016 SHALL frame a write as N=16 bits: command byte {0,addr} then wdata.
REQ-017 SHALL frame a read as N=24 bits: command byte {1,addr}, dummy byte 0x00, then a received data byte; spi_mosi=0 during bits 8..23.
REQ-018 SHALL implement states IDLE, SETUP, SHIFT, HOLD, GAP; IDLE->SETUP on start=1, SETUP->SHIFT after H=CLK_DIV cycles, SHIFT->HOLD after bit N-1 falling edge, HOLD->GAP after H cycles, GAP->IDLE after H cycles.
REQ-019 SHALL, with accept edge = e0, latch rw/addr/wdata, drive spi_cs_n=0 and busy=1 at e0.
REQ-020 SHALL drive spi_clk rising at e(H+2Hk) and falling at e(2H+2Hk), k=0..N-1; spi_clk=0 outside SHIFT.
REQ-021 SHALL drive spi_cs_n=1 at e(2HN+H) and assert done with busy=0 at e(2HN+2H), done high exactly one cycle.
REQ-022 SHALL ignore start while busy=1; start sampled in IDLE at the edge after completion SHALL be accepted (back-to-back, cs_n high >= H cycles guaranteed by GAP).
REQ-023 SHALL shift received bits 16..23 into rdata shadow and update rdata at the done edge of reads only; rdata held otherwise, unchanged by writes.
REQ-024 SHALL hold spi_mosi=0 in IDLE, SETUP before first rise, and after last bit.
REQ-025 SHALL use an 8-bit half-period counter and a 5-bit bit counter; no wrap beyond N.
REQ-026 SHALL not synchronize spi_miso; peripheral timing guarantees setup to the falling-edge capture.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously force IDLE, spi_cs_n=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rdata=0x00, counters 0.
REQ-028 SHALL abort any in-flight transaction on reset with no done pulse; first start after release behaves as from power-up.

Verification
REQ-029 SHALL cover: reset asserted -> cs_n=1, spi_clk=0, mosi=0, busy=0, done=0, rdata=0x00.
REQ-030 SHALL cover: CLK_DIV=2, write addr=0x05 wdata=0xA5 -> 16 spi_clk rises, peripheral model samples 0x05 then 0xA5 on falling edges, cs_n high at e66, done at e68.
REQ-031 SHALL cover: CLK_DIV=2, read addr=0x03, model drives 0x3C on rising edges of bits 16..23 -> mosi bytes 0x83,0x00, 24 rises, done at e100, rdata=0x3C.
REQ-032 SHALL cover: start pulsed mid-transaction -> ignored; start held high -> second transaction accepted at edge after done, cs_n high >= CLK_DIV cycles between frames.
REQ-033 SHALL cover: rst_n low during bit 5 of a write -> outputs idle immediately, no done; subsequent write 0x01/0x7E completes correctly.
REQ-034 SHALL cover: CLK_DIV=1 write -> rises at e1,e3..e31, cs_n high at e33, done at e34.

Source files
------------

// File: rtl/spi_reg_master.sv
// SPI register-access master (CPOL=0, CPHA=1): 16-bit write frames and 24-bit read frames.
// Every output is registered. All timing comes from one half-period counter and one bit counter.
module spi_reg_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n
);
    localparam logic [7:0] HalfLast = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        rw_q, rw_d;
    logic        clk_q, clk_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        half_end;
    logic [4:0]  last_bit;

    assign half_end = (cnt_q == HalfLast);
    assign last_bit = rw_q ? 5'd23 : 5'd15;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rw_d    = rw_q;
        clk_d   = clk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                clk_d  = 1'b0;
                mosi_d = 1'b0;
                if (start) begin
                    state_d = StSetup;
                    cnt_d   = 8'd0;
                    bit_d   = 5'd0;
                    rw_d    = rw;
                    // Read frames send a zero dummy byte and then zeros while the reply shifts in.
                    tx_d    = rw ? {1'b1, addr, 16'h0000} : {1'b0, addr, wdata, 8'h00};
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            StSetup: begin
                if (half_end) begin
                    state_d = StShift;
                    cnt_d   = 8'd0;
                    clk_d   = 1'b1;
                    mosi_d  = tx_q[23];
                    tx_d    = {tx_q[22:0], 1'b0};
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StShift: begin
                if (!half_end) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = 8'd0;
                    if (clk_q) begin
                        // Falling edge: capture, then either advance or end the frame.
                        clk_d = 1'b0;
                        if (bit_q[4]) begin
                            rx_d = {rx_q[6:0], spi_miso};
                        end
                        if (bit_q == last_bit) begin
                            state_d = StHold;
                            mosi_d  = 1'b0;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end else begin
                        clk_d  = 1'b1;
                        mosi_d = tx_q[23];
                        tx_d   = {tx_q[22:0], 1'b0};
                    end
                end
            end

            StHold: begin
                if (half_end) begin
                    state_d = StGap;
                    cnt_d   = 8'd0;
                    cs_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StGap: begin
                if (half_end) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (rw_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            bit_q   <= 5'd0;
            tx_q    <= 24'd0;
            rx_q    <= 8'd0;
            rw_q    <= 1'b0;
            clk_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rw_q    <= rw_d;
            clk_q   <= clk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign spi_clk  = clk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: two instances (CLK_DIV=2 and CLK_DIV=1) with a peripheral model.
// Edge numbers are counted from the accept edge and compared with the frame timing rules.
module tb_spi_reg_master;
    logic       sclk;
    logic       rst_s   [2];
    logic       start_s [2];
    logic       rw_s    [2];
    logic [6:0] addr_s  [2];
    logic [7:0] wdata_s [2];
    logic       miso_s  [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic [7:0] rdata_s [2];
    logic       sck_s   [2];
    logic       mosi_s  [2];
    logic       cs_s    [2];

    int         tests;
    int         fails;
    int         hdiv      [2];
    logic [7:0] exp_rdata [2];
    time        last_cs_time;

    spi_reg_master #(.CLK_DIV(2)) u_dut_div2 (
        .sclk(sclk), .rst_n(rst_s[0]), .start(start_s[0]), .rw(rw_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .busy(busy_s[0]), .done(done_s[0]), .rdata(rdata_s[0]),
        .spi_clk(sck_s[0]), .spi_mosi(mosi_s[0]), .spi_miso(miso_s[0]), .spi_cs_n(cs_s[0])
    );

    spi_reg_master #(.CLK_DIV(1)) u_dut_div1 (
        .sclk(sclk), .rst_n(rst_s[1]), .start(start_s[1]), .rw(rw_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .busy(busy_s[1]), .done(done_s[1]), .rdata(rdata_s[1]),
        .spi_clk(sck_s[1]), .spi_mosi(mosi_s[1]), .spi_miso(miso_s[1]), .spi_cs_n(cs_s[1])
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endfunction

    task automatic chk_idle(input int d);
        chk("idle_cs_n", int'(cs_s[d]), 1);
        chk("idle_spi_clk", int'(sck_s[d]), 0);
        chk("idle_mosi", int'(mosi_s[d]), 0);
        chk("idle_busy", int'(busy_s[d]), 0);
        chk("idle_done", int'(done_s[d]), 0);
        chk("idle_rdata", int'(rdata_s[d]), int'(exp_rdata[d]));
    endtask

    // One transaction with a CPHA=1 peripheral: it shifts its byte out on spi_clk rises and
    // samples mosi on falls. pre: start is already high; keep: leave start high afterwards.
    task automatic run_txn(input int d, input bit rw, input logic [6:0] a, input logic [7:0] w,
                           input logic [7:0] rb, input int exp_cs, input int exp_done,
                           input int pulse_at, input bit pre, input bit keep);
        int          h, n, rises, falls, first_rise, last_rise, cs_edge, done_edge, bad, k;
        logic [23:0] frame, miso_pat, sent;
        logic        prev_clk, prev_mosi;
        h        = hdiv[d];
        n        = rw ? 24 : 16;
        frame    = {rw, a, (rw ? 8'h00 : w), 8'h00};
        miso_pat = {16'($urandom), rb};
        if (!pre) @(negedge sclk);
        rw_s[d]    = rw;
        addr_s[d]  = a;
        wdata_s[d] = w;
        start_s[d] = 1'b1;
        @(posedge sclk); #1;
        if (pre) chk("cs_gap_ge_h", int'((($time - last_cs_time) / 10) >= h), 1);
        chk("accept_busy", int'(busy_s[d]), 1);
        chk("accept_cs_n", int'(cs_s[d]), 0);
        if (!keep) start_s[d] = 1'b0;
        rises = 0; falls = 0; first_rise = -1; last_rise = -1;
        cs_edge = -1; done_edge = -1; bad = 0; sent = '0;
        prev_clk  = sck_s[d];
        prev_mosi = mosi_s[d];
        for (int e = 1; e <= exp_done + 4 && done_edge < 0; e++) begin
            if (e == pulse_at) start_s[d] = 1'b1;
            if (e == pulse_at + 1) start_s[d] = 1'b0;
            @(posedge sclk); #1;
            if (!prev_clk && sck_s[d]) begin
                if (first_rise < 0) first_rise = e;
                last_rise = e;
                k = rises;
                rises++;
                if (k < 24) miso_s[d] = miso_pat[23 - k];
            end
            if (prev_clk && !sck_s[d]) begin
                falls++;
                sent = {sent[22:0], prev_mosi};
            end
            if (cs_s[d] && cs_edge < 0) begin
                cs_edge      = e;
                last_cs_time = $time;
            end
            if (mosi_s[d] && (cs_s[d] || rises == 0 || falls >= n)) bad++;
            if (sck_s[d] && cs_s[d]) bad++;
            if (done_s[d]) begin
                done_edge = e;
                chk("done_busy_low", int'(busy_s[d]), 0);
            end else if (rdata_s[d] !== exp_rdata[d]) begin
                bad++;
            end
            prev_clk  = sck_s[d];
            prev_mosi = mosi_s[d];
        end
        if (rw) exp_rdata[d] = rb;
        chk("spi_clk_rises", rises, n);
        chk("spi_clk_falls", falls, n);
        chk("first_rise_edge", first_rise, h);
        chk("last_rise_edge", last_rise, h + 2 * h * (n - 1));
        chk("mosi_frame", int'(sent), int'(frame >> (24 - n)));
        chk("cs_n_high_edge", cs_edge, exp_cs);
        chk("done_edge", done_edge, exp_done);
        chk("idle_levels_and_rdata_hold", bad, 0);
        chk("rdata", int'(rdata_s[d]), int'(exp_rdata[d]));
        if (!keep) begin
            bad = 0;
            for (int i = 0; i < 4; i++) begin
                @(posedge sclk); #1;
                if (done_s[d] || busy_s[d] || !cs_s[d]) bad++;
            end
            chk("post_done_idle", bad, 0);
        end
    endtask

    typedef struct {
        int         d;
        bit         rw;
        logic [6:0] a;
        logic [7:0] w;
        logic [7:0] rb;
        int         exp_cs;
        int         exp_done;
        int         pulse_at;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int cnt;
        tests = 0;
        fails = 0;
        hdiv[0] = 2;
        hdiv[1] = 1;
        last_cs_time = 0;
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b0; start_s[d] = 1'b0; rw_s[d] = 1'b0;
            addr_s[d] = '0; wdata_s[d] = '0; miso_s[d] = 1'b0; exp_rdata[d] = 8'h00;
        end
        vecs[0] = '{0, 1'b0, 7'h05, 8'hA5, 8'h00, 66, 68, -1};
        vecs[1] = '{0, 1'b1, 7'h03, 8'hFF, 8'h3C, 98, 100, -1};
        vecs[2] = '{1, 1'b0, 7'h5A, 8'hC3, 8'h00, 33, 34, -1};
        vecs[3] = '{0, 1'b0, 7'h11, 8'h22, 8'h00, 66, 68, 20};
        vecs[4] = '{1, 1'b1, 7'h7F, 8'h00, 8'h81, 49, 50, -1};

        #12;
        chk_idle(0);
        chk_idle(1);
        @(negedge sclk);
        rst_s[0] = 1'b1;
        rst_s[1] = 1'b1;

        foreach (vecs[i]) begin
            run_txn(vecs[i].d, vecs[i].rw, vecs[i].a, vecs[i].w, vecs[i].rb,
                    vecs[i].exp_cs, vecs[i].exp_done, vecs[i].pulse_at, 1'b0, 1'b0);
        end

        // Start held high across completion: next frame begins on the edge after done.
        run_txn(0, 1'b0, 7'h21, 8'h96, 8'h00, 66, 68, -1, 1'b0, 1'b1);
        run_txn(0, 1'b1, 7'h42, 8'h00, 8'h5A, 98, 100, -1, 1'b1, 1'b0);

        // Reset in the middle of bit 5 of a write.
        @(negedge sclk);
        rw_s[0] = 1'b0; addr_s[0] = 7'h12; wdata_s[0] = 8'h34; start_s[0] = 1'b1;
        @(posedge sclk); #1;
        start_s[0] = 1'b0;
        repeat (22) @(posedge sclk);
        #1;
        chk("abort_in_bit5_clk_high", int'(sck_s[0]), 1);
        #2 rst_s[0] = 1'b0;
        #1;
        exp_rdata[0] = 8'h00;
        chk_idle(0);
        @(negedge sclk);
        rst_s[0] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge sclk); #1;
            if (done_s[0] || busy_s[0]) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        run_txn(0, 1'b0, 7'h01, 8'h7E, 8'h00, 66, 68, -1, 1'b0, 1'b0);

        // Random traffic; timing expectations from the frame rules.
        for (int i = 0; i < 16; i++) begin
            int         dd, hh, nn;
            bit         r;
            logic [6:0] a;
            logic [7:0] w, rb;
            dd = i % 2;
            hh = hdiv[dd];
            r  = 1'($urandom_range(0, 1));
            a  = 7'($urandom);
            w  = 8'($urandom);
            rb = 8'($urandom);
            nn = r ? 24 : 16;
            run_txn(dd, r, a, w, rb, 2 * hh * nn + hh, 2 * hh * nn + 2 * hh, -1, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
